// File: rtl/wb_port_arbiter_if.sv
// Bundle of the three result-source handshakes, the flush input and the
// writeback-stage outputs shared by the writeback port arbiter.
`timescale 1ns/1ps
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int EXC_W  = 3
);
    logic              alu_valid;
    logic              alu_ready;
    logic [DATA_W-1:0] alu_data;
    logic [RD_W-1:0]   alu_rd;
    logic [EXC_W-1:0]  alu_exc;

    logic              mem_valid;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data;
    logic [RD_W-1:0]   mem_rd;
    logic [EXC_W-1:0]  mem_exc;

    logic              mul_valid;
    logic              mul_ready;
    logic [DATA_W-1:0] mul_data;
    logic [RD_W-1:0]   mul_rd;
    logic [EXC_W-1:0]  mul_exc;

    logic              flush;

    logic              wb_we;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [EXC_W-1:0]  wb_exception;
    logic [1:0]        wb_src;

    // Arbiter side: consumes results, drives grants and the writeback stage.
    modport slave (
        input  alu_valid, alu_data, alu_rd, alu_exc,
        input  mem_valid, mem_data, mem_rd, mem_exc,
        input  mul_valid, mul_data, mul_rd, mul_exc,
        input  flush,
        output alu_ready, mem_ready, mul_ready,
        output wb_we, wb_rd, wb_data, wb_exception, wb_src
    );

    // Pipeline side: produces results and observes grants/writeback.
    modport master (
        output alu_valid, alu_data, alu_rd, alu_exc,
        output mem_valid, mem_data, mem_rd, mem_exc,
        output mul_valid, mul_data, mul_rd, mul_exc,
        output flush,
        input  alu_ready, mem_ready, mul_ready,
        input  wb_we, wb_rd, wb_data, wb_exception, wb_src
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: fixed priority MEM > MUL > ALU with
// age-based promotion of starved sources, feeding a one-cycle writeback stage.
`timescale 1ns/1ps
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int RD_W         = 5,
    parameter int EXC_W        = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    wb_port_arbiter_if.slave   bus
);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_ALU  = 2'b01;
    localparam logic [1:0] SRC_MEM  = 2'b10;
    localparam logic [1:0] SRC_MUL  = 2'b11;

    logic [AGE_W-1:0]  age_alu_q, age_alu_d;
    logic [AGE_W-1:0]  age_mem_q, age_mem_d;
    logic [AGE_W-1:0]  age_mul_q, age_mul_d;

    logic              starve_alu_s, starve_mem_s, starve_mul_s;
    logic              gnt_alu_s, gnt_mem_s, gnt_mul_s;

    logic              wb_we_q, wb_we_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [EXC_W-1:0]  wb_exc_q, wb_exc_d;
    logic [1:0]        wb_src_q, wb_src_d;

    // Writes to x0 and faulting results never reach the register file.
    function automatic logic wb_we_f(input logic [RD_W-1:0] rd, input logic [EXC_W-1:0] exc);
        return (rd != '0) && (exc == '0);
    endfunction

    function automatic logic [AGE_W-1:0] age_next_f(input logic [AGE_W-1:0] age,
                                                     input logic valid,
                                                     input logic gnt,
                                                     input logic flush);
        logic [AGE_W-1:0] nxt;
        if (flush || !valid || gnt) begin
            nxt = '0;
        end else if (age == AGE_MAX) begin
            nxt = age;
        end else begin
            nxt = age + AGE_W'(1);
        end
        return nxt;
    endfunction

    assign starve_alu_s = bus.alu_valid && (age_alu_q == AGE_MAX);
    assign starve_mem_s = bus.mem_valid && (age_mem_q == AGE_MAX);
    assign starve_mul_s = bus.mul_valid && (age_mul_q == AGE_MAX);

    // Grant selection: starved sources first, base priority inside each tier.
    always_comb begin
        gnt_alu_s = 1'b0;
        gnt_mem_s = 1'b0;
        gnt_mul_s = 1'b0;
        if (!reset || bus.flush) begin
            gnt_alu_s = 1'b0;
        end else if (starve_mem_s) begin
            gnt_mem_s = 1'b1;
        end else if (starve_mul_s) begin
            gnt_mul_s = 1'b1;
        end else if (starve_alu_s) begin
            gnt_alu_s = 1'b1;
        end else if (bus.mem_valid) begin
            gnt_mem_s = 1'b1;
        end else if (bus.mul_valid) begin
            gnt_mul_s = 1'b1;
        end else if (bus.alu_valid) begin
            gnt_alu_s = 1'b1;
        end else begin
            gnt_alu_s = 1'b0;
        end
    end

    assign bus.alu_ready = gnt_alu_s;
    assign bus.mem_ready = gnt_mem_s;
    assign bus.mul_ready = gnt_mul_s;

    // Age counter next state.
    always_comb begin
        age_alu_d = age_next_f(age_alu_q, bus.alu_valid, gnt_alu_s, bus.flush);
        age_mem_d = age_next_f(age_mem_q, bus.mem_valid, gnt_mem_s, bus.flush);
        age_mul_d = age_next_f(age_mul_q, bus.mul_valid, gnt_mul_s, bus.flush);
    end

    // Writeback stage next state; rd/data hold on idle cycles.
    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_exc_d  = '0;
        wb_src_d  = SRC_NONE;
        case ({gnt_mul_s, gnt_mem_s, gnt_alu_s})
            3'b001: begin
                wb_we_d   = wb_we_f(bus.alu_rd, bus.alu_exc);
                wb_rd_d   = bus.alu_rd;
                wb_data_d = bus.alu_data;
                wb_exc_d  = bus.alu_exc;
                wb_src_d  = SRC_ALU;
            end
            3'b010: begin
                wb_we_d   = wb_we_f(bus.mem_rd, bus.mem_exc);
                wb_rd_d   = bus.mem_rd;
                wb_data_d = bus.mem_data;
                wb_exc_d  = bus.mem_exc;
                wb_src_d  = SRC_MEM;
            end
            3'b100: begin
                wb_we_d   = wb_we_f(bus.mul_rd, bus.mul_exc);
                wb_rd_d   = bus.mul_rd;
                wb_data_d = bus.mul_data;
                wb_exc_d  = bus.mul_exc;
                wb_src_d  = SRC_MUL;
            end
            default: begin
                wb_we_d  = 1'b0;
                wb_exc_d = '0;
                wb_src_d = SRC_NONE;
            end
        endcase
    end

    // State registers: age counters and writeback stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_alu_q <= '0;
            age_mem_q <= '0;
            age_mul_q <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_exc_q  <= '0;
            wb_src_q  <= SRC_NONE;
        end else begin
            age_alu_q <= age_alu_d;
            age_mem_q <= age_mem_d;
            age_mul_q <= age_mul_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_exc_q  <= wb_exc_d;
            wb_src_q  <= wb_src_d;
        end
    end

    assign bus.wb_we        = wb_we_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_exception = wb_exc_q;
    assign bus.wb_src       = wb_src_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single transfers, starvation
// promotion, x0 suppression, exception reporting and flush.
`timescale 1ns/1ps
module tb_wb_port_arbiter;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_mis;

    wb_port_arbiter_if #(.DATA_W(32), .RD_W(5), .EXC_W(3)) bus ();

    wb_port_arbiter #(
        .DATA_W(32), .RD_W(5), .EXC_W(3), .STARVE_LIMIT(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdy();
        return {29'd0, bus.mul_ready, bus.mem_ready, bus.alu_ready};
    endfunction

    task automatic chk_wb(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] data, input logic [2:0] exc, input logic [1:0] src);
        chk({tag, "_we"},   32'(bus.wb_we), 32'(we));
        chk({tag, "_rd"},   32'(bus.wb_rd), 32'(rd));
        chk({tag, "_data"}, bus.wb_data, data);
        chk({tag, "_exc"},  32'(bus.wb_exception), 32'(exc));
        chk({tag, "_src"},  32'(bus.wb_src), 32'(src));
    endtask

    logic [2:0] exp_rdy[7];
    logic [1:0] exp_src[7];

    initial begin
        n_cmp = 0;
        n_mis = 0;
        bus.alu_valid = 1'b0; bus.alu_data = 32'd0; bus.alu_rd = 5'd0; bus.alu_exc = 3'd0;
        bus.mem_valid = 1'b0; bus.mem_data = 32'd0; bus.mem_rd = 5'd0; bus.mem_exc = 3'd0;
        bus.mul_valid = 1'b0; bus.mul_data = 32'd0; bus.mul_rd = 5'd0; bus.mul_exc = 3'd0;
        bus.flush = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h55;
        #2;
        chk_wb("rst", 1'b0, 5'd0, 32'd0, 3'd0, 2'b00);
        chk("rst_ready", rdy(), 32'd0);

        // Release reset, mem transfer, then async reset mid-transfer.
        tick();
        reset = 1'b1;
        #1 chk("t1_ready", rdy(), 32'b010);
        tick();
        chk_wb("t1_wb", 1'b1, 5'd3, 32'h55, 3'd0, 2'b10);
        bus.mem_rd = 5'd4; bus.mem_data = 32'h66;
        #2 reset = 1'b0;
        #1;
        chk_wb("t1_async", 1'b0, 5'd0, 32'd0, 3'd0, 2'b00);
        chk("t1_rst_ready", rdy(), 32'd0);
        #2 reset = 1'b1;
        #1 chk("t1_rel_ready", rdy(), 32'b010);
        tick();
        chk_wb("t1_first", 1'b1, 5'd4, 32'h66, 3'd0, 2'b10);
        bus.mem_valid = 1'b0;

        // Single ALU transfer, then an idle cycle holding rd/data.
        bus.alu_valid = 1'b1; bus.alu_data = 32'hAA; bus.alu_rd = 5'd5;
        #1 chk("t2_ready", rdy(), 32'b001);
        tick();
        chk_wb("t2_wb", 1'b1, 5'd5, 32'hAA, 3'd0, 2'b01);
        bus.alu_valid = 1'b0;
        tick();
        chk_wb("idle", 1'b0, 5'd5, 32'hAA, 3'd0, 2'b00);

        // All three sources valid: mem x4, starved mul, starved alu, mem.
        exp_rdy = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010};
        exp_src = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b10};
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA1;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 32'hB2;
        bus.mul_valid = 1'b1; bus.mul_rd = 5'd3; bus.mul_data = 32'hC3;
        for (int i = 0; i < 7; i++) begin
            #1 chk($sformatf("t3_ready%0d", i), rdy(), 32'(exp_rdy[i]));
            tick();
            chk($sformatf("t3_src%0d", i), 32'(bus.wb_src), 32'(exp_src[i]));
        end
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.mul_valid = 1'b0;
        tick();
        chk("t3_idle_src", 32'(bus.wb_src), 32'd0);

        // MUL result to x0: retired without a write.
        bus.mul_valid = 1'b1; bus.mul_rd = 5'd0; bus.mul_data = 32'h1234;
        #1 chk("t4_ready", rdy(), 32'b100);
        tick();
        chk_wb("t4_wb", 1'b0, 5'd0, 32'h1234, 3'd0, 2'b11);
        bus.mul_valid = 1'b0;

        // ALU result carrying an exception.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77; bus.alu_exc = 3'b010;
        #1 chk("t5_ready", rdy(), 32'b001);
        tick();
        chk_wb("t5_wb", 1'b0, 5'd7, 32'h77, 3'b010, 2'b01);
        bus.alu_valid = 1'b0; bus.alu_exc = 3'd0;
        tick();
        chk_wb("t5_after", 1'b0, 5'd7, 32'h77, 3'd0, 2'b00);

        // Age mul to 3 behind mem, then flush.
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd8; bus.mem_data = 32'h88;
        bus.mul_valid = 1'b1; bus.mul_rd = 5'd9; bus.mul_data = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("t6_pre%0d", i), rdy(), 32'b010);
            tick();
        end
        bus.flush = 1'b1;
        #1 chk("t6_flush_ready", rdy(), 32'd0);
        tick();
        bus.flush = 1'b0;
        chk_wb("t6_wb", 1'b0, 5'd8, 32'h88, 3'd0, 2'b00);
        // With ages cleared, mul needs four more mem grants before promotion.
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("t6_post%0d", i), rdy(), (i == 4) ? 32'b100 : 32'b010);
            tick();
        end
        chk_wb("t6_mul", 1'b1, 5'd9, 32'h99, 3'd0, 2'b11);
        bus.mem_valid = 1'b0; bus.mul_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
